// File: rtl/div_seq4b_if.sv
// Start/busy/done handshake and operand/result bus between the controlling FSM and the divider.
interface div_seq4b_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         busy;
  logic         done;
  logic         div0;

  modport master (output start, A, B, input Q, R, busy, done, div0);
  modport slave  (input start, A, B, output Q, R, busy, done, div0);
endinterface

// File: rtl/div_seq4b.sv
// Restoring unsigned divider, one quotient bit per clock: done N+1 edges after accept (1 edge if B==0).
// No backpressure: start is only honoured in IDLE/DONE, ignored while busy.
module div_seq4b #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  div_seq4b_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N:0]    r_rem;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_r;
  logic          r_div0;

  logic          w_accept;
  logic          w_last;
  logic [N:0]    w_rem_sh;
  logic [N:0]    w_diff;
  logic          w_ge;
  logic [N:0]    w_rem_nxt;
  logic [N-1:0]  w_a_nxt;

  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(N - 1));

  // Partial remainder stays below the divisor, so its top bit is always 0 and can be dropped on shift.
  assign w_rem_sh  = {r_rem[N-1:0], r_a[N-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_ge      = ~w_diff[N];
  assign w_rem_nxt = w_ge ? w_diff : w_rem_sh;
  assign w_a_nxt   = {r_a[N-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = (bus.B == '0) ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_div0 <= 1'b0;
    end else if (w_accept) begin
      if (bus.B == '0) begin
        r_q    <= '1;
        r_r    <= bus.A;
        r_div0 <= 1'b1;
      end else begin
        r_a    <= bus.A;
        r_b    <= bus.B;
        r_rem  <= '0;
        r_cnt  <= '0;
        r_div0 <= 1'b0;
      end
    end else if (r_state == S_CALC) begin
      r_a   <= w_a_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_q <= w_a_nxt;
        r_r <= w_rem_nxt[N-1:0];
      end
    end
  end

  assign bus.Q    = r_q;
  assign bus.R    = r_r;
  assign bus.busy = (r_state == S_CALC);
  assign bus.done = (r_state == S_DONE);
  assign bus.div0 = r_div0;
endmodule

// File: tb/tb_div_seq4b.sv
// Bench for div_seq4b: directed cases, full operand sweep and random back-to-back traffic vs arithmetic model.
module tb_div_seq4b;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  div_seq4b_if #(.N(N)) bus ();

  div_seq4b #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_q(input int a, input int b);
    return (b == 0) ? 8'((1 << N) - 1) : 8'(a / b);
  endfunction

  function automatic logic [7:0] model_r(input int a, input int b);
    return (b == 0) ? 8'(a) : 8'(a % b);
  endfunction

  // mode 0: inputs quiet during CALC; 1: random start pulses/operands; 2: operands switched to 0/1.
  // chain: leave the next accept to the following call so it lands on the DONE cycle.
  task automatic do_op(input int a, input int b, input int mode, input bit chain);
    bus.start = 1'b1;
    bus.A     = 4'(a);
    bus.B     = 4'(b);
    step();
    bus.start = 1'b0;
    if (b != 0) begin
      for (int i = 0; i < N; i++) begin
        check("busy_calc", 8'(bus.busy), 8'd1);
        check("done_calc", 8'(bus.done), 8'd0);
        if (i == 0) check("div0_clr", 8'(bus.div0), 8'd0);
        if (mode == 1) begin
          bus.start = 1'($urandom_range(0, 1));
          bus.A     = 4'($urandom);
          bus.B     = 4'($urandom);
        end else if (mode == 2) begin
          bus.A = 4'd0;
          bus.B = 4'd1;
        end
        step();
      end
      bus.start = 1'b0;
    end
    check("done_pulse", 8'(bus.done), 8'd1);
    check("busy_done",  8'(bus.busy), 8'd0);
    check("q",          8'(bus.Q),    model_q(a, b));
    check("r",          8'(bus.R),    model_r(a, b));
    check("div0",       8'(bus.div0), (b == 0) ? 8'd1 : 8'd0);
    if (!chain) begin
      step();
      check("done_fall", 8'(bus.done), 8'd0);
      check("q_hold",    8'(bus.Q),    model_q(a, b));
      check("div0_hold", 8'(bus.div0), (b == 0) ? 8'd1 : 8'd0);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #12;
    check("rst_q",    8'(bus.Q),    8'd0);
    check("rst_r",    8'(bus.R),    8'd0);
    check("rst_busy", 8'(bus.busy), 8'd0);
    check("rst_done", 8'(bus.done), 8'd0);
    check("rst_div0", 8'(bus.div0), 8'd0);
    rst_n = 1'b1;
    step();

    do_op(13, 3, 0, 1'b0);
    do_op(15, 1, 0, 1'b0);
    do_op(3,  9, 0, 1'b0);
    do_op(7,  0, 0, 1'b0);
    check("div0_busy_never", 8'(bus.busy), 8'd0);
    do_op(13, 3, 0, 1'b0);
    do_op(13, 3, 0, 1'b1);
    do_op(10, 4, 0, 1'b0);
    do_op(13, 3, 1, 1'b0);
    do_op(13, 3, 2, 1'b0);

    // Abort mid-calculation: outputs clear at once and no done appears.
    bus.start = 1'b1;
    bus.A     = 4'd9;
    bus.B     = 4'd2;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("abort_q",    8'(bus.Q),    8'd0);
    check("abort_r",    8'(bus.R),    8'd0);
    check("abort_busy", 8'(bus.busy), 8'd0);
    check("abort_done", 8'(bus.done), 8'd0);
    check("abort_div0", 8'(bus.div0), 8'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      step();
      check("abort_no_done", 8'(bus.done), 8'd0);
    end
    do_op(13, 3, 0, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(a, b, int'($urandom_range(0, 1)), 1'b0);
      end
    end

    for (int k = 0; k < 60; k++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    bus.start = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
